// File: rtl/uart_pkt_parser.sv
// Assembles 14-byte command frames (SOF FUNC D1..D10 CSUM EOF) from UART byte strobes,
// validates them and publishes the payload with a one-cycle pack_done pulse.
module uart_pkt_parser #(
    parameter logic [7:0]  _SOF         = 8'h5A,
    parameter logic [7:0]  _EOF         = 8'hA5,
    parameter int unsigned _TIMEOUT_CYC = 50000
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] func_reg,
    output logic [7:0] rev_data1,
    output logic [7:0] rev_data2,
    output logic [7:0] rev_data3,
    output logic [7:0] rev_data4,
    output logic [7:0] rev_data5,
    output logic [7:0] rev_data6,
    output logic [7:0] rev_data7,
    output logic [7:0] rev_data8,
    output logic [7:0] rev_data9,
    output logic [7:0] rev_data10,
    output logic       pack_done,
    output logic       chk_err,
    output logic       frm_err,
    output logic       busy,
    output logic [2:0] fsm_state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FUNC = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_EOF  = 3'd4
    } state_t;

    localparam logic [19:0] CNT_LAST = 20'(_TIMEOUT_CYC - 1);

    state_t      state, state_next;
    logic [3:0]  idx;
    logic [7:0]  sum;
    logic [7:0]  csum_rx;
    logic [19:0] cnt;
    logic [7:0]  shadow_func;
    logic [7:0]  shadow [0:9];
    logic [7:0]  rev_q  [0:9];
    logic        expire, commit, chk_fire, frm_fire;

    assign fsm_state  = state;
    assign rev_data1  = rev_q[0];
    assign rev_data2  = rev_q[1];
    assign rev_data3  = rev_q[2];
    assign rev_data4  = rev_q[3];
    assign rev_data5  = rev_q[4];
    assign rev_data6  = rev_q[5];
    assign rev_data7  = rev_q[6];
    assign rev_data8  = rev_q[7];
    assign rev_data9  = rev_q[8];
    assign rev_data10 = rev_q[9];

    always_ff @(posedge clk_50M) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Input handshake: rx_done qualifies rx_data for exactly one cycle; there is no
    // backpressure, so every strobe is consumed in the cycle it appears.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        chk_fire   = 1'b0;
        frm_fire   = 1'b0;
        expire     = (state != S_IDLE) && !rx_done && (cnt == CNT_LAST);
        if (expire) begin
            state_next = S_IDLE;
            frm_fire   = 1'b1;
        end else if (rx_done) begin
            case (state)
                S_IDLE: if (rx_data == _SOF) state_next = S_FUNC;
                S_FUNC: state_next = S_DATA;
                S_DATA: if (idx == 4'd9) state_next = S_CSUM;
                S_CSUM: state_next = S_EOF;
                S_EOF: begin
                    state_next = S_IDLE;
                    // A bad EOF outranks a bad checksum.
                    if (rx_data != _EOF)    frm_fire = 1'b1;
                    else if (csum_rx != sum) chk_fire = 1'b1;
                    else                     commit   = 1'b1;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            idx         <= 4'd0;
            sum         <= 8'h00;
            csum_rx     <= 8'h00;
            cnt         <= 20'd0;
            shadow_func <= 8'h00;
            func_reg    <= 8'h00;
            pack_done   <= 1'b0;
            chk_err     <= 1'b0;
            frm_err     <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                shadow[i] <= 8'h00;
                rev_q[i]  <= 8'h00;
            end
        end else begin
            pack_done <= commit;
            chk_err   <= chk_fire;
            frm_err   <= frm_fire;
            busy      <= (state_next != S_IDLE);

            if (rx_done || state == S_IDLE) cnt <= 20'd0;
            else                            cnt <= cnt + 20'd1;

            if (rx_done) begin
                case (state)
                    S_FUNC: begin
                        shadow_func <= rx_data;
                        sum         <= rx_data;
                        idx         <= 4'd0;
                    end
                    S_DATA: begin
                        shadow[idx] <= rx_data;
                        sum         <= sum + rx_data;
                        if (idx != 4'd9) idx <= idx + 4'd1;
                    end
                    S_CSUM:  csum_rx <= rx_data;
                    default: ;
                endcase
            end

            if (commit) begin
                func_reg <= shadow_func;
                for (int i = 0; i < 10; i++) rev_q[i] <= shadow[i];
            end
        end
    end
endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed and randomized frame stimulus for uart_pkt_parser, checked against a
// frame-level model (byte sum, EOF test) and pulse counters.
module tb_uart_pkt_parser;
    localparam int TMO = 100;
    localparam logic [7:0] SOF_B = 8'h5A;
    localparam logic [7:0] EOF_B = 8'hA5;

    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] func_reg;
    logic [7:0] rev_data1, rev_data2, rev_data3, rev_data4, rev_data5;
    logic [7:0] rev_data6, rev_data7, rev_data8, rev_data9, rev_data10;
    logic       pack_done, chk_err, frm_err, busy;
    logic [2:0] fsm_state;

    uart_pkt_parser #(._TIMEOUT_CYC(TMO)) dut (
        .clk_50M(clk_50M), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .func_reg(func_reg),
        .rev_data1(rev_data1), .rev_data2(rev_data2), .rev_data3(rev_data3),
        .rev_data4(rev_data4), .rev_data5(rev_data5), .rev_data6(rev_data6),
        .rev_data7(rev_data7), .rev_data8(rev_data8), .rev_data9(rev_data9),
        .rev_data10(rev_data10),
        .pack_done(pack_done), .chk_err(chk_err), .frm_err(frm_err), .busy(busy),
        .fsm_state(fsm_state)
    );

    always #5 clk_50M = ~clk_50M;

    wire [79:0] rev_all = {rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
                           rev_data6, rev_data7, rev_data8, rev_data9, rev_data10};

    int total = 0;
    int bad = 0;
    int exp_pack = 0, exp_chk = 0, exp_frm = 0;
    int seen_pack = 0, seen_chk = 0, seen_frm = 0, excl_viol = 0;
    int gap_max = 0;
    logic [7:0]  frm [14];
    logic [7:0]  exp_func = 8'h00;
    logic [79:0] exp_rev = 80'h0;

    always @(negedge clk_50M) begin
        seen_pack += int'(pack_done);
        seen_chk  += int'(chk_err);
        seen_frm  += int'(frm_err);
        if ($countones({pack_done, chk_err, frm_err}) > 1) excl_viol++;
    end

    task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom_range(0, 255));
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_byte(frm[i]);
            if (i < last) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic load_plan_frame();
        logic [7:0] plan [14];
        plan = '{8'h5A, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h20, 8'h05,
                 8'h00, 8'h00, 8'h00, 8'h0F, 8'h45, 8'hA5};
        frm = plan;
    endtask

    task automatic fix_csum();
        int s;
        s = 0;
        for (int i = 1; i <= 11; i++) s += int'(frm[i]);
        frm[12] = 8'(s % 256);
    endtask

    // Called right after the last byte strobe: the verdict must be visible now.
    task automatic check_outcome(input string tag);
        int s;
        int c;
        s = 0;
        for (int i = 1; i <= 11; i++) s += int'(frm[i]);
        if (frm[13] != EOF_B)             c = 2;
        else if (8'(s % 256) != frm[12])  c = 1;
        else                              c = 0;
        if (c == 0) begin
            exp_func = frm[1];
            for (int i = 0; i < 10; i++) exp_rev[8*(9-i) +: 8] = frm[i+2];
            exp_pack++;
        end else if (c == 1) exp_chk++;
        else exp_frm++;
        check({tag, "/pack"}, pack_done, c == 0);
        check({tag, "/chk"},  chk_err,   c == 1);
        check({tag, "/frm"},  frm_err,   c == 2);
        check({tag, "/func"}, func_reg,  exp_func);
        check({tag, "/rev"},  rev_all,   exp_rev);
    endtask

    task automatic check_idle(input string tag);
        tick();
        check({tag, "/pulses_low"}, {pack_done, chk_err, frm_err}, 3'b000);
        check({tag, "/busy_low"}, busy, 1'b0);
    endtask

    task automatic run_frame(input string tag);
        send_range(0, 13);
        check_outcome(tag);
    endtask

    task automatic random_frame();
        frm[0] = SOF_B;
        for (int i = 1; i <= 11; i++) frm[i] = 8'($urandom_range(0, 255));
        fix_csum();
        frm[13] = EOF_B;
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check("rst/func", func_reg, 8'h00);
        check("rst/rev", rev_all, 80'h0);
        check("rst/flags", {pack_done, chk_err, frm_err, busy}, 4'b0000);
        rst = 1'b0;
        tick();

        // Stray bytes in IDLE are ignored
        send_byte(8'h00); check("stray/busy0", busy, 1'b0);
        send_byte(8'hFF); check("stray/busy1", busy, 1'b0);
        send_byte(8'hA5); check("stray/busy2", busy, 1'b0);
        check("stray/pulses", {pack_done, chk_err, frm_err}, 3'b000);

        // Reference good frame, back-to-back bytes; busy follows the SOF strobe
        gap_max = 0;
        load_plan_frame();
        send_byte(frm[0]);
        check("plan/busy_rise", busy, 1'b1);
        send_range(1, 13);
        check_outcome("plan");
        check("plan/const_rev", rev_all, 80'h00_00_10_00_20_05_00_00_00_0F);
        check("plan/const_func", func_reg, 8'h01);
        check_idle("plan");

        // Checksum error keeps previous outputs; next good frame decodes
        gap_max = 3;
        load_plan_frame(); frm[12] = 8'h46;
        run_frame("badcsum"); check_idle("badcsum");
        random_frame();
        run_frame("after_chk"); check_idle("after_chk");

        // Bad EOF, and bad EOF plus bad checksum, both report frm_err only
        load_plan_frame(); frm[13] = 8'hA4;
        run_frame("badeof"); check_idle("badeof");
        load_plan_frame(); frm[13] = 8'hA4; frm[12] = 8'h46;
        run_frame("badeof_csum"); check_idle("badeof_csum");

        // Checksum wrap and payload carrying SOF/EOF values
        frm[0] = SOF_B; frm[1] = 8'hFF;
        for (int i = 2; i <= 11; i++) frm[i] = 8'h01;
        frm[12] = 8'h09; frm[13] = EOF_B;
        run_frame("wrap"); check_idle("wrap");
        random_frame();
        frm[1] = SOF_B; frm[3] = EOF_B; frm[7] = SOF_B; frm[11] = EOF_B;
        fix_csum();
        run_frame("sof_eof_data"); check_idle("sof_eof_data");

        // Timeout fires TMO idle cycles after the last strobe
        gap_max = 0;
        random_frame();
        send_range(0, 2);
        repeat (TMO - 1) tick();
        check("tmo/no_err_yet", frm_err, 1'b0);
        check("tmo/busy_yet", busy, 1'b1);
        tick();
        exp_frm++;
        check("tmo/frm_err", frm_err, 1'b1);
        check("tmo/busy_drop", busy, 1'b0);
        tick();
        check("tmo/frm_err_pulse", frm_err, 1'b0);
        random_frame();
        run_frame("tmo_recover"); check_idle("tmo_recover");

        // A byte landing on the expiry cycle is accepted
        random_frame();
        send_range(0, 2);
        repeat (TMO - 1) tick();
        send_byte(frm[3]);
        check("edge/no_frm", frm_err, 1'b0);
        check("edge/busy", busy, 1'b1);
        send_range(4, 13);
        check_outcome("edge"); check_idle("edge");

        // Reset mid-frame aborts silently and clears outputs
        gap_max = 2;
        random_frame();
        send_range(0, 6);
        rst = 1'b1;
        tick();
        check("midrst/out", {func_reg, rev_all}, 88'h0);
        check("midrst/flags", {pack_done, chk_err, frm_err, busy}, 4'b0000);
        tick();
        rst = 1'b0;
        exp_func = 8'h00; exp_rev = 80'h0;
        check("midrst/hold", {func_reg, rev_all}, 88'h0);
        random_frame();
        run_frame("post_rst"); check_idle("post_rst");

        // Two frames with no idle cycle between them
        gap_max = 0;
        random_frame();
        run_frame("b2b_a");
        random_frame();
        run_frame("b2b_b");
        check_idle("b2b");

        // Randomized frames with occasional corruption and stray idle bytes
        for (int n = 0; n < 24; n++) begin
            int mode;
            gap_max = $urandom_range(0, 12);
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] junk;
                junk = 8'($urandom_range(0, 255));
                if (junk == SOF_B) junk = 8'h00;
                send_byte(junk);
            end
            random_frame();
            mode = $urandom_range(0, 3);
            if (mode == 1 || mode == 3) frm[12] = frm[12] ^ 8'($urandom_range(1, 255));
            if (mode == 2 || mode == 3) frm[13] = frm[13] ^ 8'($urandom_range(1, 255));
            run_frame($sformatf("rnd%0d", n));
            check_idle($sformatf("rnd%0d", n));
        end

        repeat (2) tick();
        check("cnt/pack", seen_pack, exp_pack);
        check("cnt/chk", seen_chk, exp_chk);
        check("cnt/frm", seen_frm, exp_frm);
        check("cnt/exclusive", excl_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_pkt_parser.md
# uart_pkt_parser

Frame decoder between the UART byte receiver and the PWM/DAC register mapper. It assembles a fixed 14-byte command frame from single-byte receive strobes. It checks start, checksum and end bytes, and enforces an inter-byte timeout. On a good frame it presents func_reg and rev_data1..rev_data10 together with a one-cycle pack_done pulse in the clk_50M domain.

## Interface
- _SOF, 8'h5A, start-of-frame byte
- _EOF, 8'hA5, end-of-frame byte
- _TIMEOUT_CYC, 50000, max clk_50M cycles between bytes inside a frame (1 ms at 50 MHz); legal range 2..2^20-1
- clk_50M  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid while rx_done is high
- rx_done  in  1  one-cycle strobe per received byte
- func_reg  out  8  function code of last good frame
- rev_data1..rev_data10  out  8 each  payload bytes 1..10 of last good frame
- pack_done  out  1  one-cycle pulse: outputs updated with a good frame
- chk_err  out  1  one-cycle pulse: checksum mismatch, frame dropped
- frm_err  out  1  one-cycle pulse: bad EOF byte or timeout, frame dropped
- busy  out  1  high while a frame is in progress (state != IDLE)

## Operation
- Frame byte order: SOF, FUNC, D1..D10, CSUM, EOF (14 bytes).
- CSUM = (FUNC + D1 + … + D10) mod 256, 8-bit wrap.
- States:
  - IDLE: rx_done with rx_data == _SOF → FUNC. Any other byte is ignored (no error).
  - FUNC: byte → shadow func; running sum = byte; idx = 0; → DATA.
  - DATA: byte → shadow[idx]; sum += byte; idx == 9 → CSUM, else idx++.
  - CSUM: store received checksum; → EOF.
  - EOF: byte != _EOF → frm_err. Else checksum != sum → chk_err. Else commit shadow to outputs and assert pack_done. Always → IDLE.
- Bytes equal to _SOF/_EOF inside FUNC/DATA/CSUM are ordinary data; there is no escaping or resync.
- Bad EOF and bad checksum together → frm_err only.
- Output registers change only on commit. They hold their values across dropped frames.
- Inter-byte timeout:
  - The counter clears on every rx_done and in IDLE; otherwise it increments.
  - When it reaches _TIMEOUT_CYC-1 outside IDLE: next cycle state = IDLE and frm_err pulses; shadow data is discarded.
  - If rx_done coincides with the expiry cycle, the byte is accepted and the timeout does not fire.
- Reset: state IDLE, idx 0, sum 0, counter 0; func_reg, rev_data1..10 = 8'h00; pack_done, chk_err, frm_err, busy = 0.
- Reset asserted mid-frame aborts the frame silently (no error pulse). Outputs return to 0.

## Timing
- All outputs are registered.
- EOF byte strobe at cycle T → func_reg/rev_data valid and pack_done = 1 at T+1; pack_done = 0 at T+2.
- chk_err/frm_err are asserted at T+1 for exactly one cycle.
- pack_done, chk_err and frm_err are mutually exclusive in any cycle.
- busy rises the cycle after the SOF strobe and falls the cycle after the EOF strobe (or timeout).
- Back-to-back rx_done on consecutive cycles must be accepted without loss. A SOF strobe at T+1 after an EOF strobe at T starts a new frame.
- Payload is stable from pack_done until the next pack_done; the downstream samples on pack_done.

## Test plan
- Good frame 5A 01 00 00 10 00 20 05 00 00 00 0F 45 A5 → one pack_done; func_reg = 01, rev_data3 = 10, rev_data5 = 20, rev_data6 = 05, rev_data10 = 0F; others 00.
- Same frame with CSUM = 46 → chk_err single pulse, no pack_done, outputs keep prior values; the following good frame decodes normally.
- Same frame with last byte A4 → frm_err pulse only; stray bytes 00 FF A5 before SOF in IDLE → ignored, busy stays 0.
- _TIMEOUT_CYC = 100: send SOF, FUNC, D1, then idle → frm_err 100 cycles after the D1 strobe, busy drops. A byte arriving exactly on the expiry cycle is instead accepted.
- Checksum wrap: FUNC = FF, D1..D10 = 01 → CSUM 09 accepted. Payload containing 5A and A5 as data decodes correctly.
- rst asserted after byte 7, then the full good frame → no error pulse, outputs 00 during reset, frame decodes; two good frames back-to-back with no idle cycle → two pack_done pulses.
